// File: rtl/regs_pkg.sv
// regs_pkg: bank control encodings and request-op helpers shared by the writeback sequencer.
package regs_pkg;
   localparam logic [2:0] CTRL_FULL = 3'b000;
   localparam logic [2:0] CTRL_LOW  = 3'b001;
   localparam logic [2:0] CTRL_HIGH = 3'b010;
   localparam logic [2:0] CTRL_PC   = 3'b011;
   localparam logic [2:0] CTRL_NOP  = 3'b111;
   localparam logic [2:0] OP_SPLIT  = 3'b100;
   localparam logic [3:0] PC_REG    = 4'hF;
   localparam int ENTRY_W = 39;

   function automatic logic op_writes(input logic [2:0] op);
      return op <= OP_SPLIT;
   endfunction

   function automatic logic [3:0] op_target(input logic [2:0] op, input logic [3:0] r);
      return (op == CTRL_PC) ? PC_REG : r;
   endfunction
endpackage

// File: rtl/regs_wb_fifo.sv
// regs_wb_fifo: request FIFO of {op, reg, data} entries with an occupancy vector for hazard lookup.
module regs_wb_fifo
   import regs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_push,
   input  logic                              i_pop,
   input  logic [ENTRY_W-1:0]                i_din,
   output logic [ENTRY_W-1:0]                o_dout,
   output logic [AW:0]                       o_count,
   output logic [DEPTH-1:0][ENTRY_W-1:0]     o_entries,
   output logic [DEPTH-1:0]                  o_valid
);
   logic [DEPTH-1:0][ENTRY_W-1:0] r_mem;
   logic [AW-1:0]                 r_wr;
   logic [AW-1:0]                 r_rd;
   logic [AW:0]                   r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end

   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr] <= i_din;

   // an entry is live when its distance from the read pointer is below the count
   always_comb begin
      o_valid = '0;
      for (int i = 0; i < DEPTH; i++)
         o_valid[i] = {1'b0, AW'(i) - r_rd} < r_count;
   end

   assign o_dout    = r_mem[r_rd];
   assign o_count   = r_count;
   assign o_entries = r_mem;
endmodule

// File: rtl/regs_writeback.sv
// regs_writeback: buffers register write requests and drains them as one bank write beat per cycle,
// splitting 32-bit immediates into low/high beats and flagging pending-write hazards.
module regs_writeback
   import regs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [3:0]  req_reg,
   input  logic [31:0] req_data,
   output logic [3:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic [2:0]  wb_control,
   input  logic [3:0]  chk_reg,
   output logic        chk_busy,
   output logic        idle
);
   logic [ENTRY_W-1:0]            w_head;
   logic [AW:0]                   w_count;
   logic [DEPTH-1:0][ENTRY_W-1:0] w_entries;
   logic [DEPTH-1:0]              w_valid;
   logic                          w_push;
   logic                          w_pop;
   logic                          w_busy;
   logic [2:0]                    w_op;
   logic [3:0]                    w_reg;
   logic [31:0]                   w_data;
   logic                          r_split;
   logic [3:0]                    r_split_reg;
   logic [15:0]                   r_split_hi;

   assign req_ready = (w_count < (AW+1)'(DEPTH)) && !rst;
   assign w_push    = req_valid && req_ready;
   assign w_pop     = !r_split && (w_count != '0);
   assign {w_op, w_reg, w_data} = w_head;

   regs_wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_din     ({req_op, req_reg, req_data}),
      .o_dout    (w_head),
      .o_count   (w_count),
      .o_entries (w_entries),
      .o_valid   (w_valid)
   );

   // beat selection: pending high half first, then FIFO head, else a no-write beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_split     <= 1'b0;
         r_split_reg <= '0;
         r_split_hi  <= '0;
         wb_control  <= CTRL_NOP;
         wb_reg      <= '0;
         wb_data     <= '0;
      end else if (r_split) begin
         r_split    <= 1'b0;
         wb_control <= CTRL_HIGH;
         wb_reg     <= r_split_reg;
         wb_data    <= {16'h0, r_split_hi};
      end else if (w_pop) begin
         if (w_op == OP_SPLIT) begin
            r_split     <= 1'b1;
            r_split_reg <= w_reg;
            r_split_hi  <= w_data[31:16];
            wb_control  <= CTRL_LOW;
            wb_reg      <= w_reg;
            wb_data     <= {16'h0, w_data[15:0]};
         end else if (op_writes(w_op)) begin
            wb_control <= w_op;
            wb_reg     <= op_target(w_op, w_reg);
            wb_data    <= w_data;
         end else begin
            wb_control <= CTRL_NOP;
         end
      end else begin
         wb_control <= CTRL_NOP;
      end
   end

   always_comb begin
      w_busy = (r_split && (r_split_reg == chk_reg)) ||
               ((wb_control != CTRL_NOP) && (wb_reg == chk_reg));
      for (int i = 0; i < DEPTH; i++)
         if (w_valid[i] && op_writes(w_entries[i][38:36]) &&
             (op_target(w_entries[i][38:36], w_entries[i][35:32]) == chk_reg))
            w_busy = 1'b1;
   end

   assign chk_busy = w_busy;
   assign idle     = (w_count == '0) && !r_split && (wb_control == CTRL_NOP);
endmodule

// File: tb/tb_regs_writeback.sv
// tb_regs_writeback: directed vectors with hand-computed beats for the writeback sequencer.
module tb_regs_writeback;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [3:0]  req_reg;
   logic [31:0] req_data;
   logic [3:0]  wb_reg;
   logic [31:0] wb_data;
   logic [2:0]  wb_control;
   logic [3:0]  chk_reg;
   logic        chk_busy;
   logic        idle;

   int          total = 0;
   int          bad = 0;
   logic        mon_en = 1'b0;
   logic [38:0] beats[$];

   regs_writeback #(.DEPTH(4), .AW(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_reg    (req_reg),
      .req_data   (req_data),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data),
      .wb_control (wb_control),
      .chk_reg    (chk_reg),
      .chk_busy   (chk_busy),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mon_en && wb_control !== 3'b111) beats.push_back({wb_control, wb_reg, wb_data});

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic [2:0] c, input logic [3:0] r, input logic [31:0] d);
      check(tag, {wb_control, wb_reg, wb_data}, {c, r, d});
   endtask

   initial begin
      int acc;
      int stall_at;
      rst = 1'b1;
      req_valid = 1'b1;
      req_op = 3'b000;
      req_reg = 4'd5;
      req_data = 32'h12345678;
      chk_reg = 4'd0;
      tick;
      tick;
      beat("reset_beat", 3'b111, 4'd0, 32'h0);
      check("reset_ready", req_ready, 0);
      check("reset_idle", idle, 1);
      rst = 1'b0;
      req_valid = 1'b0;
      tick;
      check("reset_nothing_accepted", idle, 1);

      // single FULL
      req_valid = 1'b1; req_op = 3'b000; req_reg = 4'd3; req_data = 32'h55555555;
      #1 check("full_ready", req_ready, 1);
      tick;
      req_valid = 1'b0;
      check("full_no_bypass", wb_control, 3'b111);
      check("full_not_idle", idle, 0);
      tick;
      beat("full_beat", 3'b000, 4'd3, 32'h55555555);
      tick;
      check("full_done_ctrl", wb_control, 3'b111);
      check("full_done_idle", idle, 1);

      // SPLIT with hazard tracking on reg 7
      chk_reg = 4'd7;
      req_valid = 1'b1; req_op = 3'b100; req_reg = 4'd7; req_data = 32'hDEADBEEF;
      tick;
      req_valid = 1'b0;
      #1 check("split_busy_queued", chk_busy, 1);
      tick;
      beat("split_lo", 3'b001, 4'd7, 32'h0000BEEF);
      check("split_busy_lo", chk_busy, 1);
      tick;
      beat("split_hi", 3'b010, 4'd7, 32'h0000DEAD);
      check("split_busy_hi", chk_busy, 1);
      tick;
      check("split_done_ctrl", wb_control, 3'b111);
      check("split_busy_clear", chk_busy, 0);
      check("split_idle", idle, 1);

      // back-to-back FULLs drain one per cycle without stalling
      beats.delete();
      mon_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1; req_op = 3'b000; req_reg = 4'(10 + k); req_data = 32'hF0000000 + k;
         #1 check($sformatf("b2b_ready%0d", k), req_ready, 1);
         tick;
      end
      req_valid = 1'b0;
      for (int c = 0; c < 20 && beats.size() < 5; c++) tick;
      check("b2b_count", beats.size(), 5);
      for (int k = 0; k < beats.size(); k++)
         check($sformatf("b2b_beat%0d", k), beats[k], {3'b000, 4'(10 + k), 32'hF0000000 + k});
      for (int c = 0; c < 20 && !idle; c++) tick;
      mon_en = 1'b0;

      // SPLITs drain at half rate, so the FIFO fills after exactly 7 accepts
      beats.delete();
      mon_en = 1'b1;
      acc = 0;
      stall_at = -1;
      for (int c = 0; c < 40 && acc < 8; c++) begin
         req_valid = 1'b1; req_op = 3'b100; req_reg = 4'(acc + 1);
         req_data = {12'hD00, 4'(acc + 1), 12'hB00, 4'(acc + 1)};
         #1;
         if (req_ready) acc++;
         else if (stall_at < 0) stall_at = acc;
         tick;
      end
      req_valid = 1'b0;
      check("fill_stall_after", stall_at, 7);
      check("fill_accepts", acc, 8);
      for (int c = 0; c < 60 && beats.size() < 16; c++) tick;
      check("fill_beat_count", beats.size(), 16);
      for (int k = 0; k < beats.size(); k++)
         check($sformatf("fill_beat%0d", k), beats[k],
               (k % 2 == 0) ? {3'b001, 4'(k / 2 + 1), 28'h000B00, 4'(k / 2 + 1)}
                            : {3'b010, 4'(k / 2 + 1), 28'h000D00, 4'(k / 2 + 1)});
      for (int c = 0; c < 20 && !idle; c++) tick;
      mon_en = 1'b0;
      check("fill_idle", idle, 1);

      // PC then invalid op; PC entries target register 15
      chk_reg = 4'hF;
      req_valid = 1'b1; req_op = 3'b011; req_reg = 4'd2; req_data = 32'h33333333;
      tick;
      req_op = 3'b110; req_reg = 4'hF; req_data = 32'h99999999;
      #1 check("pc_busy_queued", chk_busy, 1);
      tick;
      req_valid = 1'b0;
      beat("pc_beat", 3'b011, 4'hF, 32'h33333333);
      tick;
      beat("invalid_nop", 3'b111, 4'hF, 32'h33333333);
      check("invalid_not_busy", chk_busy, 0);
      check("invalid_idle", idle, 1);

      // reset while the low half of a SPLIT is on the outputs
      chk_reg = 4'd9;
      req_valid = 1'b1; req_op = 3'b100; req_reg = 4'd9; req_data = 32'h12345678;
      tick;
      req_valid = 1'b0;
      tick;
      beat("rsplit_lo", 3'b001, 4'd9, 32'h00005678);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      beat("rsplit_cleared", 3'b111, 4'd0, 32'h0);
      #1 check("rsplit_idle", idle, 1);
      check("rsplit_not_busy", chk_busy, 0);
      tick;
      check("rsplit_no_hi", wb_control, 3'b111);
      check("rsplit_idle2", idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
